// File: rtl/spi_master_param.sv
// spi_master_param
//   Parametrised SPI master. It takes a parallel word plus a one-cycle start
//   request, serialises the word MSB first on mosi and collects a word of the
//   same width from miso. An internal loopback option collects the master's
//   own mosi instead. SPI mode, sclk rate and burst chip-select hold are
//   chosen per word and latched when the start is accepted.
//
// Ports
//   i_clk            system clock
//   i_reset          asynchronous, active-high reset
//   i_start          one-cycle request, accepted only while o_busy=0
//   i_tx_data        word to send, latched on an accepted start
//   i_mode           {CPOL,CPHA}, latched on an accepted start
//   i_freq_control   selects the sclk half-period HALF_P0..HALF_P3
//   i_loopback       1: the sampled bit is the mosi register, miso ignored
//   i_burst_hold     1: keep cs_bar low after the word for a following start
//   i_miso           serial data from the slave
//   o_sclk           SPI clock
//   o_mosi           serial data to the slave
//   o_cs_bar         active-low chip select
//   o_busy           high from the accepted start until the tx_done cycle
//   o_rx_data        last received word, held until the next word completes
//   o_rx_valid       one-cycle pulse, o_rx_data updated in the same cycle
//   o_tx_done        one-cycle pulse, coincident with o_rx_valid

module spi_master_param #(
  parameter int DATA_WIDTH = 16,
  parameter int HALF_P0    = 1,
  parameter int HALF_P1    = 2,
  parameter int HALF_P2    = 5,
  parameter int HALF_P3    = 25
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic [1:0]            i_mode,
  input  logic [1:0]            i_freq_control,
  input  logic                  i_loopback,
  input  logic                  i_burst_hold,
  input  logic                  i_miso,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_cs_bar,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_tx_done
);

  // The half-period counter only has to reach the largest table entry minus one.
  localparam int HMAX_A = (HALF_P0 > HALF_P1) ? HALF_P0 : HALF_P1;
  localparam int HMAX_B = (HALF_P2 > HALF_P3) ? HALF_P2 : HALF_P3;
  localparam int HMAX   = (HMAX_A > HMAX_B) ? HMAX_A : HMAX_B;
  localparam int CW     = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam int EW     = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH);

  // S_DONE is the single cycle carrying rx_valid/tx_done; cs_bar is still low
  // there and only rises on the way back to S_IDLE.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_DONE,
    S_HELD
  } state_t;

  state_t                r_state;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_cs_bar;
  logic                  r_busy;
  logic                  r_rx_valid;
  logic                  r_tx_done;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_loop;
  logic                  r_hold;
  logic [CW-1:0]         r_half;
  logic [CW-1:0]         r_cnt;
  logic [EW-1:0]         r_edge_cnt;

  logic [CW-1:0]         w_sel_half;
  logic                  w_accept;
  logic                  w_tick;
  logic [EW-1:0]         w_next_edge;
  logic                  w_edge;
  logic                  w_sample;
  logic                  w_rx_bit;

  // Half-period table lookup, stored as H-1 so the counter compares directly.
  always_comb begin
    w_sel_half = CW'(HALF_P0 - 1);
    case (i_freq_control)
      2'b01:   w_sel_half = CW'(HALF_P1 - 1);
      2'b10:   w_sel_half = CW'(HALF_P2 - 1);
      2'b11:   w_sel_half = CW'(HALF_P3 - 1);
      default: w_sel_half = CW'(HALF_P0 - 1);
    endcase
  end

  // A start is taken whenever busy is low: idle, chip-select held, or the
  // done cycle itself.
  assign w_accept    = i_start && ((r_state == S_IDLE) || (r_state == S_HELD) ||
                                   (r_state == S_DONE));
  assign w_tick      = (r_cnt == r_half);
  assign w_next_edge = r_edge_cnt + EW'(1);
  // An sclk edge falls at the end of LEAD and at the end of every SHIFT
  // half-period except the one that follows the final edge.
  assign w_edge      = w_tick && ((r_state == S_LEAD) ||
                                  ((r_state == S_SHIFT) && (r_edge_cnt != LAST_EDGE)));
  // Odd edges are leading edges; CPHA picks whether they sample or shift.
  assign w_sample    = w_next_edge[0] ^ r_cpha;
  assign w_rx_bit    = r_loop ? r_mosi : i_miso;

  // Single state machine: sequencing, sclk generation, shifting and the
  // registered outputs all live here so every output comes straight off a flop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_bar   <= 1'b1;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_done  <= 1'b0;
      r_rx_data  <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_loop     <= 1'b0;
      r_hold     <= 1'b0;
      r_half     <= '0;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_done  <= 1'b0;
      if (w_accept) begin
        r_tx       <= i_tx_data;
        r_cpol     <= i_mode[1];
        r_cpha     <= i_mode[0];
        r_half     <= w_sel_half;
        r_loop     <= i_loopback;
        r_busy     <= 1'b1;
        r_cs_bar   <= 1'b0;
        r_sclk     <= i_mode[1];
        r_mosi     <= i_tx_data[DATA_WIDTH-1];
        r_rx       <= '0;
        r_cnt      <= '0;
        r_edge_cnt <= '0;
        r_state    <= S_LEAD;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cs_bar <= 1'b1;
            r_sclk   <= i_mode[1];
          end
          S_LEAD: begin
            if (w_tick) begin
              r_cnt   <= '0;
              r_state <= S_SHIFT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_SHIFT: begin
            if (w_tick) begin
              r_cnt <= '0;
              if (r_edge_cnt == LAST_EDGE) begin
                r_state <= S_TRAIL;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_TRAIL: begin
            if (w_tick) begin
              r_cnt      <= '0;
              r_hold     <= i_burst_hold;
              r_busy     <= 1'b0;
              r_rx_valid <= 1'b1;
              r_tx_done  <= 1'b1;
              r_rx_data  <= r_rx;
              r_state    <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DONE: begin
            if (r_hold) begin
              r_state <= S_HELD;
            end else begin
              r_state  <= S_IDLE;
              r_cs_bar <= 1'b1;
            end
          end
          S_HELD: begin
            r_sclk <= r_cpol;
            if (!i_burst_hold) begin
              r_state  <= S_IDLE;
              r_cs_bar <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase

        // The sample is taken in the same clock cycle as the sampling sclk
        // edge; CPHA=0 does not shift after the final trailing edge.
        if (w_edge) begin
          r_sclk     <= ~r_sclk;
          r_edge_cnt <= w_next_edge;
          if (w_sample) begin
            r_rx <= {r_rx[DATA_WIDTH-2:0], w_rx_bit};
          end else if (w_next_edge != LAST_EDGE) begin
            r_mosi <= r_cpha ? r_tx[DATA_WIDTH-1] : r_tx[DATA_WIDTH-2];
            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign o_sclk     = r_sclk;
  assign o_mosi     = r_mosi;
  assign o_cs_bar   = r_cs_bar;
  assign o_busy     = r_busy;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_tx_done  = r_tx_done;

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param
//   Scoreboard bench for spi_master_param. Stimulus pushes the expected word,
//   slave-observed mosi word and done cycle; a monitor pops on every tx_done.
//   A small SPI slave model drives miso and collects mosi from the sclk edges.
//   A second 8-bit instance covers a narrow word with a directed transfer.

module tb_spi_master_param;

  logic        clk = 1'b0;
  int          cyc = 0;

  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_tx_data = '0;
  logic [1:0]  i_mode = '0;
  logic [1:0]  i_freq_control = '0;
  logic        i_loopback = 1'b0;
  logic        i_burst_hold = 1'b0;
  logic        i_miso = 1'b0;
  logic        o_sclk, o_mosi, o_cs_bar, o_busy, o_rx_valid, o_tx_done;
  logic [15:0] o_rx_data;

  logic        s8Start = 1'b0;
  logic [7:0]  s8Tx = '0;
  logic [1:0]  s8Mode = '0;
  logic [1:0]  s8Freq = '0;
  logic        s8Loop = 1'b0;
  logic        o8Sclk, o8Mosi, o8CsBar, o8Busy, o8RxValid, o8TxDone;
  logic [7:0]  o8RxData;

  typedef struct {
    logic [15:0] rx;
    logic [15:0] tx;
    int          doneCyc;
  } exp_t;

  exp_t        expQ[$];
  exp_t        popped;
  int          total = 0;
  int          bad = 0;

  logic [15:0] slaveWord = '0;
  logic        curCpol = 1'b0;
  logic        curCpha = 1'b0;
  logic [15:0] slaveRx = '0;
  int          slaveEdges = 0;
  int          slaveIdx = 0;
  logic        prevSclk = 1'b0;
  logic        prevBusy = 1'b0;
  int          csHighCnt = 0;
  logic        csGlitch = 1'b0;
  logic [7:0]  s8Seen = '0;
  logic        s8PrevSclk = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spi_master_param #(.DATA_WIDTH(16)) u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_tx_data(i_tx_data),
    .i_mode(i_mode), .i_freq_control(i_freq_control), .i_loopback(i_loopback),
    .i_burst_hold(i_burst_hold), .i_miso(i_miso), .o_sclk(o_sclk), .o_mosi(o_mosi),
    .o_cs_bar(o_cs_bar), .o_busy(o_busy), .o_rx_data(o_rx_data),
    .o_rx_valid(o_rx_valid), .o_tx_done(o_tx_done)
  );

  spi_master_param #(.DATA_WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_reset(i_reset), .i_start(s8Start), .i_tx_data(s8Tx),
    .i_mode(s8Mode), .i_freq_control(s8Freq), .i_loopback(s8Loop),
    .i_burst_hold(1'b0), .i_miso(1'b0), .o_sclk(o8Sclk), .o_mosi(o8Mosi),
    .o_cs_bar(o8CsBar), .o_busy(o8Busy), .o_rx_data(o8RxData),
    .o_rx_valid(o8RxValid), .o_tx_done(o8TxDone)
  );

  // Half-period per freq_control code, straight from the divider table.
  function automatic int halfOf(input logic [1:0] f);
    case (f)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 25;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Issue one word: wait for busy low, latch the slave's reply word and
  // the bench's own copy of the mode, pulse start and record the expectation.
  task automatic applyStimulus(input logic [15:0] tx, input logic [1:0] mode,
                               input logic [1:0] freq, input logic loop,
                               input logic [15:0] sw);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (o_busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      total++;
      bad++;
      $display("[TB] FAIL busy_wait_timeout: busy still 1 after %0d cycles, required 0", guard);
    end
    slaveWord      = sw;
    curCpol        = mode[1];
    curCpha        = mode[0];
    i_tx_data      = tx;
    i_mode         = mode;
    i_freq_control = freq;
    i_loopback     = loop;
    i_start        = 1'b1;
    e.rx           = loop ? tx : sw;
    e.tx           = tx;
    e.doneCyc      = cyc + 1 + 34 * halfOf(freq);
    expQ.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Wait for the scoreboard to drain; optionally scramble inputs and pulse
  // an extra start once while the word is in flight.
  task automatic waitDone(input bit scramble);
    int n = 0;
    int at;
    at = $urandom_range(3, 60);
    while (expQ.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
      if (scramble && n == at && o_busy) begin
        i_tx_data      = 16'($urandom);
        i_mode         = 2'($urandom_range(0, 3));
        i_freq_control = 2'($urandom_range(0, 3));
        i_loopback     = 1'($urandom_range(0, 1));
        i_start        = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        n++;
      end
    end
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: %0d words pending, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  // SPI slave: restarts on each rising busy, samples mosi on sampling edges
  // and presents its next reply bit on shifting edges.
  always @(negedge clk) begin
    if (i_reset) begin
      prevBusy = 1'b0;
      prevSclk = o_sclk;
    end else begin
      if (o_busy && !prevBusy) begin
        slaveEdges = 0;
        slaveRx    = '0;
        slaveIdx   = 15;
        if (!curCpha) begin
          i_miso   = slaveWord[15];
          slaveIdx = 14;
        end
      end else if (o_busy && (o_sclk != prevSclk)) begin
        slaveEdges++;
        if ((o_sclk != curCpol) ^ curCpha) begin
          slaveRx = {slaveRx[14:0], o_mosi};
        end else if (slaveIdx >= 0) begin
          i_miso   = slaveWord[slaveIdx];
          slaveIdx = slaveIdx - 1;
        end
      end
      prevBusy = o_busy;
      prevSclk = o_sclk;
    end
  end

  // Monitor: pops one expectation per tx_done and checks data, timing and
  // chip-select behaviour of the finished word.
  always @(negedge clk) begin
    if (o_cs_bar) csHighCnt++;
    if (o_busy && o_cs_bar) csGlitch = 1'b1;
    if (o_tx_done) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_tx_done: got tx_done=1, required none (cycle %0d)", cyc);
      end else begin
        popped = expQ.pop_front();
        checkOutput("rx_data", 32'(o_rx_data), 32'(popped.rx));
        checkOutput("slave_mosi_word", 32'(slaveRx), 32'(popped.tx));
        checkOutput("done_cycle", 32'(cyc), 32'(popped.doneCyc));
        checkOutput("sclk_edges", 32'(slaveEdges), 32'd32);
        checkOutput("done_flags_rxv_busy_cs_glitch",
                    32'({o_rx_valid, o_busy, o_cs_bar, csGlitch}), 32'b1000);
      end
      csGlitch = 1'b0;
    end
  end

  // Collects the 8-bit instance's mosi on falling sclk (mode 01 sampling edge).
  always @(negedge clk) begin
    if (o8Busy && s8PrevSclk && !o8Sclk) s8Seen = {s8Seen[6:0], o8Mosi};
    s8PrevSclk = o8Sclk;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap;
    int c8;
    int n8;

    repeat (3) @(negedge clk);
    checkOutput("reset_flags_sclk_mosi_cs_busy_rxv_txd",
                32'({o_sclk, o_mosi, o_cs_bar, o_busy, o_rx_valid, o_tx_done}), 32'b001000);
    checkOutput("reset_rx_data", 32'(o_rx_data), 32'd0);
    i_reset = 1'b0;

    $display("[TB] loopback mode 00, fastest clock");
    applyStimulus(16'h55AA, 2'b00, 2'b00, 1'b1, 16'h0000);
    waitDone(1'b0);
    @(negedge clk);
    checkOutput("cs_bar_after_word", 32'(o_cs_bar), 32'd1);

    $display("[TB] mode 11, slowest clock, slave reply");
    applyStimulus(16'h1234, 2'b11, 2'b11, 1'b0, 16'hA55A);
    waitDone(1'b0);
    repeat (3) @(negedge clk);
    checkOutput("idle_sclk_cpol1", 32'(o_sclk), 32'd1);

    $display("[TB] burst with held chip select");
    i_burst_hold = 1'b1;
    applyStimulus(16'hBEEF, 2'b10, 2'b00, 1'b1, 16'($urandom));
    snap = csHighCnt;
    waitDone(1'b0);
    applyStimulus(16'hCAFE, 2'b10, 2'b01, 1'b1, 16'($urandom));
    waitDone(1'b0);
    i_mode = 2'b00;
    repeat (2) @(negedge clk);
    checkOutput("held_cs_busy_sclk", 32'({o_cs_bar, o_busy, o_sclk}), 32'b001);
    checkOutput("burst_cs_high_cycles", 32'(csHighCnt - snap), 32'd0);
    i_burst_hold = 1'b0;
    checkOutput("cs_bar_before_release", 32'(o_cs_bar), 32'd0);
    @(negedge clk);
    checkOutput("cs_bar_after_release", 32'(o_cs_bar), 32'd1);

    $display("[TB] start pulse while busy");
    applyStimulus(16'h00FF, 2'b00, 2'b01, 1'b1, 16'h0000);
    repeat (9) @(negedge clk);
    i_tx_data = 16'hFFFF;
    i_start   = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    waitDone(1'b0);

    $display("[TB] reset in the middle of a word");
    applyStimulus(16'h6B2D, 2'b00, 2'b01, 1'b1, 16'h0000);
    repeat (27) @(negedge clk);
    checkOutput("busy_before_abort", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    #1;
    checkOutput("abort_cs_sclk_busy_rxv", 32'({o_cs_bar, o_sclk, o_busy, o_rx_valid}), 32'b1000);
    checkOutput("abort_rx_data", 32'(o_rx_data), 32'd0);
    expQ.delete();
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    applyStimulus(16'h3C96, 2'b01, 2'b00, 1'b0, 16'h5E17);
    waitDone(1'b0);

    $display("[TB] randomized words");
    for (int k = 0; k < 24; k++) begin
      applyStimulus(16'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 16'($urandom));
      waitDone(1'b1);
    end

    $display("[TB] 8-bit instance");
    @(negedge clk);
    s8Tx    = 8'hA5;
    s8Mode  = 2'b01;
    s8Freq  = 2'b10;
    s8Loop  = 1'b1;
    s8Start = 1'b1;
    c8      = cyc;
    @(negedge clk);
    s8Start = 1'b0;
    n8      = 0;
    while (!o8TxDone && n8 < 500) begin
      @(negedge clk);
      n8++;
    end
    checkOutput("dut8_done_cycle", 32'(cyc - c8), 32'd91);
    checkOutput("dut8_rx_data", 32'(o8RxData), 32'hA5);
    checkOutput("dut8_mosi_word", 32'(s8Seen), 32'hA5);
    checkOutput("dut8_rxv_busy_cs", 32'({o8RxValid, o8Busy, o8CsBar}), 32'b100);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
